// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter
// Shares the Z80 system bus between up to four external bus masters. The
// arbiter raises BUSREQ to the CPU and waits for BUSACK. It then grants the
// round-robin winner for a tenure of at most 'tenure' clock cycles, where a
// tenure of 0 means the grant has no limit.
//
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_req[3:0]            level bus requests from the masters
//   o_gnt[3:0]            registered grant, one-hot or zero
//   o_busreq_n            registered Z80 BUSREQ (active-low)
//   i_busack_n            Z80 BUSACK (active-low)
//   i_cs_n/i_rd_n/i_wr_n  CPU register window select and strobes (active-low)
//   i_addr[1:0]           register index: 0 mask, 1 tenure, 2 status, 3 expcnt
//   i_data[7:0]           CPU write data
//   o_data[7:0]           combinational read data, zero when not read
//   o_expired             one-cycle pulse when the limit cuts a tenure off

module z80_bus_arbiter #(
    parameter int          NREQ       = 4,
    parameter logic [3:0]  MASK_RST   = 4'b1111,
    parameter logic [7:0]  TENURE_RST = 8'd64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_busreq_n,
    input  logic            i_busack_n,
    input  logic            i_cs_n,
    input  logic            i_rd_n,
    input  logic            i_wr_n,
    input  logic [1:0]      i_addr,
    input  logic [7:0]      i_data,
    output logic [7:0]      o_data,
    output logic            o_expired
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      state_bits;
    logic [1:0]      winner;
    logic [1:0]      last;
    logic [1:0]      next_winner;
    logic            found;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] eligible;
    logic [7:0]      tenure;
    logic [7:0]      expcnt;
    logic [7:0]      counter;
    logic            wr_en;
    logic            keep_bus;
    logic            expire_now;

    assign eligible   = i_req & mask;
    assign wr_en      = !i_cs_n && !i_wr_n;
    assign state_bits = state;

    // The tenure continues only while the winner still requests and the CPU
    // still acknowledges. If the request drops in the same cycle that the
    // limit is reached, the event counts as a drop and not as an expiry.
    assign keep_bus   = i_req[winner] && !i_busack_n;
    assign expire_now = (state == GRANT) && keep_bus && (counter == 8'd1);

    // Round-robin search. It starts one past the last winner and wraps. The
    // fourth step lands on 'last' itself, so a lone requester can win again.
    always_comb begin
        next_winner = 2'd0;
        found       = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && eligible[last + 2'(k)]) begin
                next_winner = last + 2'(k);
                found       = 1'b1;
            end
        end
    end

    // Arbitration FSM, register window and expiry counter. Only the counter
    // loaded at grant time governs a tenure, so later writes to the mask or
    // the tenure affect only the next grant.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            o_gnt      <= '0;
            o_busreq_n <= 1'b1;
            o_expired  <= 1'b0;
            last       <= 2'd3;
            winner     <= 2'd0;
            mask       <= MASK_RST;
            tenure     <= TENURE_RST;
            expcnt     <= 8'd0;
            counter    <= 8'd0;
        end else begin
            o_expired <= 1'b0;

            if (wr_en) begin
                case (i_addr)
                    2'd0:    mask   <= i_data[NREQ-1:0];
                    2'd1:    tenure <= i_data;
                    default: ;
                endcase
            end

            if (wr_en && i_addr == 2'd3) begin
                expcnt <= 8'd0;
            end else if (expire_now && expcnt != 8'hFF) begin
                expcnt <= expcnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (|eligible) begin
                        winner     <= next_winner;
                        o_busreq_n <= 1'b0;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    o_busreq_n <= 1'b0;
                    if (!i_busack_n) begin
                        if (i_req[winner]) begin
                            o_gnt[winner] <= 1'b1;
                            counter       <= tenure;
                            state         <= GRANT;
                        end else begin
                            o_busreq_n <= 1'b1;
                            last       <= winner;
                            state      <= RELEASE;
                        end
                    end
                end
                GRANT: begin
                    if (!keep_bus || expire_now) begin
                        o_gnt      <= '0;
                        o_busreq_n <= 1'b1;
                        o_expired  <= expire_now;
                        last       <= winner;
                        state      <= RELEASE;
                    end else if (counter != 8'd0) begin
                        counter <= counter - 8'd1;
                    end
                end
                RELEASE: begin
                    o_gnt      <= '0;
                    o_busreq_n <= 1'b1;
                    if (i_busack_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux for the CPU register window
    always_comb begin
        o_data = 8'h00;
        if (!i_cs_n && !i_rd_n) begin
            case (i_addr)
                2'd0:    o_data = 8'(mask);
                2'd1:    o_data = tenure;
                2'd2:    o_data = {state_bits, 1'b0, ~i_busack_n, 2'b00, winner};
                default: o_data = expcnt;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter
// Self-checking bench for z80_bus_arbiter. A simple Z80 model pulls BUSACK
// low two cycles after BUSREQ falls and releases it as soon as BUSREQ rises.
// A grant scoreboard holds the expected {requester, length} of each tenure
// and compares it when the grant ends. Register reads are table-driven.

module tb_z80_bus_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [3:0] i_req;
    logic [3:0] o_gnt;
    logic       o_busreq_n;
    logic       i_busack_n;
    logic       i_cs_n;
    logic       i_rd_n;
    logic       i_wr_n;
    logic [1:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_expired;

    typedef struct {
        int idx;
        int len;
    } gnt_exp_t;

    typedef struct {
        logic       do_wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        int         ncyc;
        logic       cs_n;
        logic       rd_n;
        logic [7:0] exp_data;
    } vec_t;

    gnt_exp_t   exp_gnt_q[$];
    logic [7:0] rd_exp_q[$];
    vec_t       vecs[14];

    int checks = 0;
    int errors = 0;
    int cur_len = 0;
    int cur_idx = 0;
    int last_len = 0;
    int exp_pulses = 0;
    int hi_run = 0;
    int min_hi = 1000;
    int low_cnt = 0;
    int onehot_bad = 0;
    int base;
    int bad;
    bit sb_on = 1'b0;
    bit mask_written;

    z80_bus_arbiter dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .o_gnt      (o_gnt),
        .o_busreq_n (o_busreq_n),
        .i_busack_n (i_busack_n),
        .i_cs_n     (i_cs_n),
        .i_rd_n     (i_rd_n),
        .i_wr_n     (i_wr_n),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_expired  (o_expired)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // One clock: sample the outputs 1 time unit after the edge, update the
    // grant scoreboard and BUSREQ statistics, then step the Z80 ack model.
    task automatic tick();
        gnt_exp_t e;
        @(posedge i_clk);
        #1;
        if (o_expired) exp_pulses++;
        if (o_gnt != 4'b0000) begin
            if (cur_len == 0) begin
                for (int b = 0; b < 4; b++) if (o_gnt[b]) cur_idx = b;
            end
            cur_len++;
            if (!$onehot(o_gnt)) onehot_bad++;
        end else if (cur_len != 0) begin
            last_len = cur_len;
            if (sb_on) begin
                if (exp_gnt_q.size() == 0) begin
                    checkOutput("unexpected_grant_idx", cur_idx, -1);
                end else begin
                    e = exp_gnt_q.pop_front();
                    checkOutput("grant_idx", cur_idx, e.idx);
                    checkOutput("grant_len", cur_len, e.len);
                end
            end
            cur_len = 0;
        end
        if (o_busreq_n) begin
            hi_run++;
        end else begin
            if (hi_run != 0 && hi_run < min_hi) min_hi = hi_run;
            hi_run = 0;
        end
        if (!o_busreq_n) low_cnt++;
        else low_cnt = 0;
        i_busack_n = !(low_cnt >= 2);
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data, input int ncyc);
        i_cs_n = 1'b0;
        i_wr_n = 1'b0;
        i_addr = addr;
        i_data = data;
        repeat (ncyc) tick();
        i_cs_n = 1'b1;
        i_wr_n = 1'b1;
    endtask

    task automatic cpu_read_check(input string name, input logic [1:0] addr, input logic [7:0] exp_data);
        i_cs_n = 1'b0;
        i_rd_n = 1'b0;
        i_addr = addr;
        rd_exp_q.push_back(exp_data);
        #1;
        checkOutput(name, int'(o_data), int'(rd_exp_q.pop_front()));
        i_cs_n = 1'b1;
        i_rd_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        if (v.do_wr) cpu_write(v.addr, v.wdata, v.ncyc);
        i_cs_n = v.cs_n;
        i_rd_n = v.rd_n;
        i_addr = v.addr;
        rd_exp_q.push_back(v.exp_data);
        #1;
        checkOutput($sformatf("reg_vec%0d", n), int'(o_data), int'(rd_exp_q.pop_front()));
        i_cs_n = 1'b1;
        i_rd_n = 1'b1;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic wait_gnt(input int budget);
        for (int c = 0; c < budget && o_gnt == 4'b0000; c++) tick();
    endtask

    initial begin
        // Register vectors: {do_wr, addr, wdata, ncyc, cs_n, rd_n, expected read}
        vecs[0]  = '{1'b0, 2'd0, 8'h00, 0, 1'b0, 1'b0, 8'h0F};
        vecs[1]  = '{1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b0, 8'h40};
        vecs[2]  = '{1'b0, 2'd2, 8'h00, 0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 2'd3, 8'h00, 0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 2'd0, 8'h35, 1, 1'b0, 1'b0, 8'h05};
        vecs[5]  = '{1'b1, 2'd0, 8'h3A, 3, 1'b0, 1'b0, 8'h0A};
        vecs[6]  = '{1'b1, 2'd1, 8'h21, 1, 1'b0, 1'b0, 8'h21};
        vecs[7]  = '{1'b1, 2'd1, 8'h21, 3, 1'b0, 1'b0, 8'h21};
        vecs[8]  = '{1'b1, 2'd2, 8'hFF, 1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 2'd3, 8'h77, 3, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 2'd1, 8'h00, 0, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 2'd0, 8'h0F, 1, 1'b0, 1'b0, 8'h0F};
        vecs[13] = '{1'b1, 2'd1, 8'h40, 1, 1'b0, 1'b0, 8'h40};

        i_reset    = 1'b1;
        i_req      = 4'b0000;
        i_busack_n = 1'b1;
        i_cs_n     = 1'b1;
        i_rd_n     = 1'b1;
        i_wr_n     = 1'b1;
        i_addr     = 2'd0;
        i_data     = 8'h00;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        checkOutput("reset_gnt", o_gnt, 0);
        checkOutput("reset_busreq_n", o_busreq_n, 1);
        checkOutput("reset_expired", o_expired, 0);

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

        // Single requester: BUSREQ one cycle after the request, grant one
        // cycle after the acknowledge is sampled, release when the request drops
        $display("[TB] single requester");
        sb_on = 1'b1;
        exp_gnt_q.push_back('{0, 6});
        i_req = 4'b0001;
        tick();
        checkOutput("t1_busreq_low", o_busreq_n, 0);
        tick();
        checkOutput("t1_no_gnt_before_ack", o_gnt, 0);
        tick();
        checkOutput("t1_gnt", o_gnt, 4'b0001);
        repeat (5) tick();
        i_req = 4'b0000;
        tick();
        checkOutput("t1_gnt_dropped", o_gnt, 0);
        checkOutput("t1_busreq_high", o_busreq_n, 1);
        repeat (3) tick();

        // Round-robin over four held requests with tenure 4. The fifth
        // request drops on the same cycle as its expiry.
        $display("[TB] round robin, tenure 4");
        pulse_reset();
        cpu_write(2'd1, 8'd4, 1);
        base   = exp_pulses;
        min_hi = 1000;
        hi_run = 0;
        exp_gnt_q.push_back('{0, 4});
        exp_gnt_q.push_back('{1, 4});
        exp_gnt_q.push_back('{2, 4});
        exp_gnt_q.push_back('{3, 4});
        exp_gnt_q.push_back('{0, 4});
        i_req = 4'b1111;
        for (int c = 0; c < 400 && exp_gnt_q.size() != 0; c++) begin
            tick();
            if (exp_gnt_q.size() == 1 && cur_len == 4) i_req = 4'b0000;
        end
        i_req = 4'b0000;
        checkOutput("t2_sb_drained", exp_gnt_q.size(), 0);
        exp_gnt_q.delete();
        checkOutput("t2_expired_pulses", exp_pulses - base, 4);
        checkOutput("t2_min_busreq_high_ge2", (min_hi >= 2) ? 1 : 0, 1);
        repeat (3) tick();
        cpu_read_check("t2_expcnt", 2'd3, 8'd4);

        // Mask 0101 alternates requesters 2 and 0. Clearing the mask during
        // the grant to 2 lets that tenure run to completion and stops BUSREQ.
        $display("[TB] mask 0101, then mask 0 mid-grant");
        cpu_write(2'd0, 8'h05, 1);
        exp_gnt_q.push_back('{2, 4});
        exp_gnt_q.push_back('{0, 4});
        exp_gnt_q.push_back('{2, 4});
        mask_written = 1'b0;
        i_req = 4'b1111;
        for (int c = 0; c < 400 && exp_gnt_q.size() != 0; c++) begin
            tick();
            i_cs_n = 1'b1;
            i_wr_n = 1'b1;
            if (!mask_written && exp_gnt_q.size() == 1 && cur_len == 2) begin
                i_cs_n = 1'b0;
                i_wr_n = 1'b0;
                i_addr = 2'd0;
                i_data = 8'h00;
                mask_written = 1'b1;
            end
        end
        i_cs_n = 1'b1;
        i_wr_n = 1'b1;
        checkOutput("t3_sb_drained", exp_gnt_q.size(), 0);
        exp_gnt_q.delete();
        bad = 0;
        repeat (12) begin
            tick();
            if (!o_busreq_n) bad++;
        end
        checkOutput("t3_no_busreq_after_mask0", bad, 0);
        cpu_read_check("t3_expcnt", 2'd3, 8'd7);
        i_req = 4'b0000;
        cpu_write(2'd0, 8'h0F, 1);

        // Unlimited tenure: the grant holds for 1000 cycles without expiry
        $display("[TB] unlimited tenure");
        cpu_write(2'd1, 8'd0, 1);
        base = exp_pulses;
        exp_gnt_q.push_back('{1, 1000});
        i_req = 4'b0010;
        wait_gnt(20);
        checkOutput("t4_gnt", o_gnt, 4'b0010);
        bad = 0;
        repeat (999) begin
            tick();
            if (o_gnt != 4'b0010) bad++;
        end
        checkOutput("t4_gnt_continuous", bad, 0);
        checkOutput("t4_no_expiry", exp_pulses - base, 0);
        i_req = 4'b0000;
        tick();
        checkOutput("t4_gnt_released", o_gnt, 0);
        checkOutput("t4_busreq_high", o_busreq_n, 1);
        repeat (3) tick();
        exp_gnt_q.delete();

        // Requester 3 withdraws while BUSREQ waits for BUSACK
        $display("[TB] drop in WAIT_ACK");
        i_req = 4'b1000;
        tick();
        checkOutput("t5_busreq_low", o_busreq_n, 0);
        i_req = 4'b0000;
        tick();
        cpu_read_check("t5_status_wait_ack", 2'd2, 8'h53);
        tick();
        checkOutput("t5_busreq_released", o_busreq_n, 1);
        checkOutput("t5_no_gnt", o_gnt, 0);
        tick();
        cpu_read_check("t5_status_idle", 2'd2, 8'h03);

        // Reset during a grant drops everything in the same cycle
        $display("[TB] reset during grant");
        sb_on = 1'b0;
        i_req = 4'b0001;
        wait_gnt(20);
        checkOutput("t6_gnt_before_reset", o_gnt, 4'b0001);
        tick();
        i_reset = 1'b1;
        tick();
        checkOutput("t6_reset_gnt", o_gnt, 0);
        checkOutput("t6_reset_busreq_n", o_busreq_n, 1);
        i_req = 4'b0000;
        tick();
        i_reset = 1'b0;
        tick();
        cpu_read_check("t6_mask", 2'd0, 8'h0F);
        cpu_read_check("t6_tenure", 2'd1, 8'h40);
        cpu_read_check("t6_status", 2'd2, 8'h00);
        cpu_read_check("t6_expcnt", 2'd3, 8'h00);

        // 300 one-cycle tenures saturate expcnt; any write to it clears it
        $display("[TB] expcnt saturation");
        cpu_write(2'd1, 8'd1, 1);
        base = exp_pulses;
        i_req = 4'b0001;
        for (int c = 0; c < 5000 && (exp_pulses - base) < 300; c++) tick();
        i_req = 4'b0000;
        checkOutput("t7_expiries", exp_pulses - base, 300);
        checkOutput("t7_tenure1_len", last_len, 1);
        repeat (4) tick();
        cpu_read_check("t7_expcnt_sat", 2'd3, 8'd255);
        cpu_write(2'd3, 8'h5A, 1);
        cpu_read_check("t7_expcnt_cleared", 2'd3, 8'd0);

        checkOutput("gnt_onehot_violations", onehot_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
